// File: rtl/noc_pkg.sv
// Shared definitions for the router input-port logic: packet FSM states and a width helper.
package noc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DROP   = 2'd2
    } state_t;

    // Bits needed to index n distinct values (never less than 1).
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/inport_multicast_distributor_if.sv
// Bus between the input-port distributor and its buffer, output arbiters and downstream lanes.
interface inport_multicast_distributor_if #(
    parameter int no_outport = 6,
    parameter int flit_size  = 4,
    parameter int phit_size  = 16
);
    logic [flit_size*phit_size-1:0]  indata;
    logic                            head;
    logic                            tail;
    logic                            empty;
    logic [no_outport-1:0]           outport_vec;
    logic [no_outport-1:0]           calls;
    logic [no_outport-1:0]           ready_vec;
    logic [no_outport*phit_size-1:0] outdata;
    logic [no_outport-1:0]           new_vec;
    logic [no_outport-1:0]           sent_req_vec;
    logic                            want;
    logic                            all_done;
    logic                            drop_err;

    modport master (
        input  indata, head, tail, empty, outport_vec, calls, ready_vec,
        output outdata, new_vec, sent_req_vec, want, all_done, drop_err
    );

    modport slave (
        output indata, head, tail, empty, outport_vec, calls, ready_vec,
        input  outdata, new_vec, sent_req_vec, want, all_done, drop_err
    );
endinterface

// File: rtl/inport_lane_counter.sv
// Per-lane phit counter with flit-complete and packet-complete flags.
module inport_lane_counter #(
    parameter int flit_size = 4,
    parameter int cnt_w     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fire,
    input  logic             pop,
    input  logic             tail,
    input  logic             clear,
    output logic [cnt_w-1:0] cnt,
    output logic             flit_done,
    output logic             pkt_done
);
    localparam logic [cnt_w-1:0] LAST = cnt_w'(flit_size - 1);

    logic [cnt_w-1:0] cnt_reg, cnt_next;
    logic             flit_done_reg, flit_done_next;
    logic             pkt_done_reg, pkt_done_next;
    logic             last_fire;

    assign last_fire = fire & (cnt_reg == LAST);

    // A pop restarts the flit even if this lane fires in the same cycle.
    always_comb begin
        cnt_next       = cnt_reg;
        flit_done_next = flit_done_reg;
        pkt_done_next  = pkt_done_reg;
        if (clear) begin
            cnt_next       = '0;
            flit_done_next = 1'b0;
            pkt_done_next  = 1'b0;
        end else if (pop) begin
            cnt_next       = '0;
            flit_done_next = 1'b0;
            pkt_done_next  = pkt_done_reg | (last_fire & tail);
        end else if (fire) begin
            cnt_next = cnt_reg + 1'b1;
            if (last_fire) begin
                flit_done_next = 1'b1;
                pkt_done_next  = pkt_done_reg | tail;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg       <= '0;
            flit_done_reg <= 1'b0;
            pkt_done_reg  <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            flit_done_reg <= flit_done_next;
            pkt_done_reg  <= pkt_done_next;
        end
    end

    assign cnt       = cnt_reg;
    assign flit_done = flit_done_reg;
    assign pkt_done  = pkt_done_reg;
endmodule

// File: rtl/inport_multicast_distributor.sv
// Input-port distributor: serialises each buffered flit phit-by-phit onto every destination lane.
module inport_multicast_distributor
    import noc_pkg::*;
#(
    parameter int no_outport                  = 6,
    parameter int flit_size                   = 4,
    parameter int floorplusone_log2_flit_size = 3,
    parameter int phit_size                   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    inport_multicast_distributor_if.master bus
);
    localparam int CW = floorplusone_log2_flit_size;
    localparam logic [CW-1:0] LAST = CW'(flit_size - 1);

    state_t                state_reg, state_next;
    logic [no_outport-1:0] dest_reg, dest_next;
    logic [no_outport-1:0] fire, lane_ok, flit_done, pkt_done;
    logic [no_outport-1:0] new_vec_reg;
    logic                  all_done_reg, all_done_next;
    logic                  drop_err_reg, drop_err_next;
    logic                  pop, clear_all, active;

    assign active = (state_reg == ST_ACTIVE);

    genvar gi;
    generate
        for (gi = 0; gi < no_outport; gi++) begin : g_lane
            logic [CW-1:0]        cnt;
            logic [phit_size-1:0] phit_sel;
            logic [phit_size-1:0] data_reg;

            inport_lane_counter #(
                .flit_size (flit_size),
                .cnt_w     (CW)
            ) u_cnt (
                .clk       (clk),
                .reset     (reset),
                .fire      (fire[gi]),
                .pop       (pop),
                .tail      (bus.tail),
                .clear     (clear_all),
                .cnt       (cnt),
                .flit_done (flit_done[gi]),
                .pkt_done  (pkt_done[gi])
            );

            assign fire[gi] = active & dest_reg[gi] & bus.calls[gi] & bus.ready_vec[gi]
                            & ~flit_done[gi] & ~bus.empty;
            // Lane no longer holds up the pop: not addressed, finished, or finishing now.
            assign lane_ok[gi] = ~dest_reg[gi] | flit_done[gi] | (fire[gi] & (cnt == LAST));

            always_comb begin
                phit_sel = '0;
                for (int k = 0; k < flit_size; k++) begin
                    if (cnt == CW'(k)) phit_sel = bus.indata[k*phit_size +: phit_size];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) data_reg <= '0;
                else       data_reg <= fire[gi] ? phit_sel : '0;
            end

            assign bus.outdata[gi*phit_size +: phit_size] = data_reg;
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        dest_next     = dest_reg;
        pop           = 1'b0;
        clear_all     = 1'b0;
        all_done_next = 1'b0;
        drop_err_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!bus.empty) begin
                    if (!bus.head) begin
                        pop           = 1'b1;
                        drop_err_next = 1'b1;
                    end else if (|bus.outport_vec) begin
                        dest_next  = bus.outport_vec;
                        clear_all  = 1'b1;
                        state_next = ST_ACTIVE;
                    end else begin
                        state_next = ST_DROP;
                    end
                end
            end
            ST_ACTIVE: begin
                if (!bus.empty && (&lane_ok)) begin
                    pop = 1'b1;
                    if (bus.tail) begin
                        dest_next     = '0;
                        clear_all     = 1'b1;
                        all_done_next = 1'b1;
                        state_next    = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (!bus.empty) begin
                    pop = 1'b1;
                    if (bus.tail) begin
                        drop_err_next = 1'b1;
                        state_next    = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            dest_reg     <= '0;
            new_vec_reg  <= '0;
            all_done_reg <= 1'b0;
            drop_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            dest_reg     <= dest_next;
            new_vec_reg  <= fire;
            all_done_reg <= all_done_next;
            drop_err_reg <= drop_err_next;
        end
    end

    assign bus.want         = pop & ~reset;
    assign bus.sent_req_vec = dest_reg & ~pkt_done & {no_outport{~reset}};
    assign bus.new_vec      = new_vec_reg;
    assign bus.all_done     = all_done_reg;
    assign bus.drop_err     = drop_err_reg;
endmodule

// File: tb/tb_inport_multicast_distributor.sv
// Bench: models the input buffer as a flit queue and checks per-lane phit streams and pulses.
module tb_inport_multicast_distributor;
    localparam int NO   = 6;
    localparam int FS   = 4;
    localparam int PS   = 16;
    localparam int HIST = 4096;

    typedef struct {
        logic [FS*PS-1:0] data;
        logic             head;
        logic             tail;
        logic [NO-1:0]    dest;
    } flit_t;

    logic clk;
    logic reset;

    inport_multicast_distributor_if #(.no_outport(NO), .flit_size(FS), .phit_size(PS)) bus ();

    inport_multicast_distributor #(
        .no_outport(NO), .flit_size(FS), .floorplusone_log2_flit_size(3), .phit_size(PS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    flit_t         q [$];
    bit            force_empty;
    int            cyc;
    logic [PS-1:0] rx [NO][$];
    int            rxc [NO][$];
    logic [PS-1:0] exp_q [NO][$];
    int            pop_cyc [$];
    int            done_cyc [$];
    int            derr_cyc [$];
    logic [NO-1:0] req_hist [HIST];
    logic [NO-1:0] cr_hist [HIST];
    int            exp_pops, exp_done, exp_derr, proto_viol;

    task automatic clear_logs();
        for (int i = 0; i < NO; i++) begin
            rx[i].delete(); rxc[i].delete(); exp_q[i].delete();
        end
        pop_cyc.delete(); done_cyc.delete(); derr_cyc.delete();
        exp_pops = 0; exp_done = 0; exp_derr = 0; proto_viol = 0;
    endtask

    // Packet-level reference: every addressed lane receives every phit of every flit in order.
    task automatic add_packet(input logic [NO-1:0] dest, input int nflits);
        flit_t fl;
        for (int f = 0; f < nflits; f++) begin
            fl.data = {$urandom, $urandom};
            fl.head = (f == 0);
            fl.tail = (f == nflits - 1);
            fl.dest = dest;
            q.push_back(fl);
            for (int i = 0; i < NO; i++)
                if (dest[i]) for (int k = 0; k < FS; k++) exp_q[i].push_back(fl.data[k*PS +: PS]);
        end
        exp_pops += nflits;
        if (dest == '0) exp_derr++;
        else            exp_done++;
    endtask

    task automatic push_orphan();
        flit_t fl;
        fl.data = {$urandom, $urandom};
        fl.head = 1'b0;
        fl.tail = $urandom_range(0, 1) == 1;
        fl.dest = NO'($urandom);
        q.push_back(fl);
        exp_pops++;
        exp_derr++;
    endtask

    task automatic drive_inputs();
        bus.empty = (q.size() == 0) || force_empty;
        if (q.size() > 0) begin
            bus.indata = q[0].data; bus.head = q[0].head; bus.tail = q[0].tail;
            bus.outport_vec = q[0].dest;
        end else begin
            bus.indata = '0; bus.head = 1'b0; bus.tail = 1'b0; bus.outport_vec = '0;
        end
    endtask

    // One clock: drive, sample at the falling edge, pop the buffer model after the rising edge.
    task automatic step();
        bit popped;
        drive_inputs();
        @(negedge clk);
        cyc++;
        req_hist[cyc % HIST] = bus.sent_req_vec;
        cr_hist[cyc % HIST]  = bus.calls & bus.ready_vec;
        for (int i = 0; i < NO; i++) begin
            if (bus.new_vec[i]) begin
                rx[i].push_back(bus.outdata[i*PS +: PS]);
                rxc[i].push_back(cyc);
                if (cr_hist[(cyc - 1) % HIST][i] !== 1'b1) proto_viol++;
            end else if (bus.outdata[i*PS +: PS] !== '0) begin
                proto_viol++;
            end
        end
        if (bus.all_done) done_cyc.push_back(cyc);
        if (bus.drop_err) derr_cyc.push_back(cyc);
        popped = (bus.want === 1'b1) && !bus.empty;
        if (popped) pop_cyc.push_back(cyc);
        @(posedge clk);
        #1;
        if (popped) void'(q.pop_front());
    endtask

    task automatic drain(input int mode, input int budget, output bit ok);
        int n;
        n = 0;
        while (q.size() > 0 && n < budget) begin
            if (mode == 1) bus.ready_vec = 6'b000011 | ((n % 2 == 1) ? 6'b100000 : 6'b000000);
            if (mode == 2) begin
                bus.calls     = NO'($urandom);
                bus.ready_vec = NO'($urandom) | NO'($urandom);
                force_empty   = ($urandom_range(0, 5) == 0);
            end
            step();
            n++;
        end
        ok = (q.size() == 0);
        force_empty = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        flit_t fl;
        fl.data = 64'h1234_5678_9abc_def0; fl.head = 1'b0; fl.tail = 1'b0; fl.dest = '1;
        q.push_back(fl);
        bus.calls = '1; bus.ready_vec = '1;
        drive_inputs();
        #1;
        tests++;
        if (bus.want !== 1'b0 || bus.sent_req_vec !== '0) begin
            fails++; $display("FAIL reset_comb: want=%b sent_req=%b, required 0/0", bus.want, bus.sent_req_vec);
        end
        tests++;
        if (bus.new_vec !== '0 || bus.outdata !== '0) begin
            fails++; $display("FAIL reset_data: new_vec=%b outdata=%h, required 0", bus.new_vec, bus.outdata);
        end
        tests++;
        if (bus.all_done !== 1'b0 || bus.drop_err !== 1'b0) begin
            fails++; $display("FAIL reset_pulses: all_done=%b drop_err=%b, required 0", bus.all_done, bus.drop_err);
        end
        q.delete();
        drive_inputs();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        clear_logs();
        repeat (2) step();
        tests++;
        if (bus.want !== 1'b0 || bus.sent_req_vec !== '0 || done_cyc.size() != 0 || derr_cyc.size() != 0) begin
            fails++; $display("FAIL reset_idle: want=%b req=%b done=%0d derr=%0d, required all 0",
                              bus.want, bus.sent_req_vec, done_cyc.size(), derr_cyc.size());
        end
        $display("[TB] reset: checks done");
    endtask

    task automatic test_unicast();
        bit ok;
        clear_logs();
        bus.calls = 6'b000100; bus.ready_vec = '1;
        add_packet(6'b000100, 2);
        drain(0, 100, ok);
        tests++;
        if (!ok || pop_cyc.size() != 2) begin
            fails++; $display("FAIL unicast_pops: drained=%0d pops=%0d, required 1/2", ok, pop_cyc.size());
        end
        for (int i = 0; i < NO; i++) begin
            int bad; bad = 0;
            for (int j = 0; j < rx[i].size() && j < exp_q[i].size(); j++) if (rx[i][j] !== exp_q[i][j]) bad++;
            tests++;
            if (bad != 0 || rx[i].size() != exp_q[i].size()) begin
                fails++; $display("FAIL unicast_data lane%0d: got %0d phits (%0d wrong), required %0d", i, rx[i].size(), bad, exp_q[i].size());
            end
        end
        if (rxc[2].size() == 8 && pop_cyc.size() == 2) begin
            tests++;
            if (rxc[2][3] != pop_cyc[0] + 1 || rxc[2][7] != pop_cyc[1] + 1) begin
                fails++; $display("FAIL unicast_want_timing: phit4@%0d phit8@%0d pops@%0d/%0d, required pop one cycle before",
                                  rxc[2][3], rxc[2][7], pop_cyc[0], pop_cyc[1]);
            end
            tests++;
            if (done_cyc.size() != 1 || done_cyc[0] != pop_cyc[1] + 1) begin
                fails++; $display("FAIL unicast_all_done: %0d pulses first@%0d, required 1 at %0d",
                                  done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, pop_cyc[1] + 1);
            end
            tests++;
            if (req_hist[pop_cyc[1] % HIST][2] !== 1'b1 || req_hist[(pop_cyc[1] + 1) % HIST][2] !== 1'b0) begin
                fails++; $display("FAIL unicast_req_drop: req at last fire=%b after=%b, required 1 then 0",
                                  req_hist[pop_cyc[1] % HIST][2], req_hist[(pop_cyc[1] + 1) % HIST][2]);
            end
        end
        $display("[TB] unicast: %0d phits on lane2, %0d pops", rx[2].size(), pop_cyc.size());
    endtask

    task automatic test_multicast();
        bit ok;
        int bad;
        clear_logs();
        bus.calls = '1; bus.ready_vec = 6'b000011;
        add_packet(6'b100011, 2);
        drain(1, 100, ok);
        tests++;
        if (!ok || pop_cyc.size() != 2 || done_cyc.size() != 1) begin
            fails++; $display("FAIL multicast_pops: drained=%0d pops=%0d done=%0d, required 1/2/1", ok, pop_cyc.size(), done_cyc.size());
        end
        for (int i = 0; i < NO; i++) begin
            bad = 0;
            for (int j = 0; j < rx[i].size() && j < exp_q[i].size(); j++) if (rx[i][j] !== exp_q[i][j]) bad++;
            tests++;
            if (bad != 0 || rx[i].size() != exp_q[i].size()) begin
                fails++; $display("FAIL multicast_data lane%0d: got %0d phits (%0d wrong), required %0d", i, rx[i].size(), bad, exp_q[i].size());
            end
        end
        if (rxc[5].size() == 8 && rxc[0].size() == 8 && pop_cyc.size() == 2) begin
            bad = 0;
            for (int k = 0; k < 2; k++) if (rxc[5][4*k+3] != pop_cyc[k] + 1) bad++;
            tests++;
            if (bad != 0) begin
                fails++; $display("FAIL multicast_want_lane5: %0d pops not aligned with lane5 phit 3, required 0", bad);
            end
            tests++;
            if (!(rxc[0][3] < rxc[5][3]) || !(rxc[0][4] > pop_cyc[0])) begin
                fails++; $display("FAIL multicast_lockstep: lane0 phit3@%0d lane5 phit3@%0d lane0 phit4@%0d pop@%0d",
                                  rxc[0][3], rxc[5][3], rxc[0][4], pop_cyc[0]);
            end
        end
        $display("[TB] multicast: lanes 0/1/5 got %0d/%0d/%0d phits", rx[0].size(), rx[1].size(), rx[5].size());
    endtask

    task automatic test_zero_dest();
        bit ok;
        int total;
        clear_logs();
        bus.calls = '1; bus.ready_vec = '1;
        add_packet(6'b000000, 3);
        drain(0, 100, ok);
        total = 0;
        for (int i = 0; i < NO; i++) total += rx[i].size();
        tests++;
        if (!ok || pop_cyc.size() != 3 || total != 0) begin
            fails++; $display("FAIL zero_dest_pops: pops=%0d phits=%0d, required 3/0", pop_cyc.size(), total);
        end
        tests++;
        if (derr_cyc.size() != 1 || done_cyc.size() != 0 || (pop_cyc.size() == 3 && derr_cyc[0] != pop_cyc[2] + 1)) begin
            fails++; $display("FAIL zero_dest_pulses: drop_err=%0d all_done=%0d, required 1/0 after tail pop",
                              derr_cyc.size(), done_cyc.size());
        end
        $display("[TB] zero_dest: %0d pops, %0d drop_err", pop_cyc.size(), derr_cyc.size());
    endtask

    task automatic test_orphan();
        bit ok;
        int bad;
        logic [NO-1:0] d;
        clear_logs();
        bus.calls = '1; bus.ready_vec = '1;
        d = NO'($urandom_range(1, 63));
        push_orphan();
        add_packet(d, 1);
        drain(0, 100, ok);
        tests++;
        if (!ok || pop_cyc.size() != exp_pops || derr_cyc.size() != 1 || derr_cyc[0] != pop_cyc[0] + 1) begin
            fails++; $display("FAIL orphan_drop: pops=%0d drop_err=%0d, required %0d/1 after first pop", pop_cyc.size(), derr_cyc.size(), exp_pops);
        end
        bad = 0;
        for (int i = 0; i < NO; i++) begin
            if (rx[i].size() != exp_q[i].size()) bad++;
            else for (int j = 0; j < rx[i].size(); j++) if (rx[i][j] !== exp_q[i][j]) bad++;
        end
        tests++;
        if (bad != 0 || done_cyc.size() != 1) begin
            fails++; $display("FAIL orphan_follow: %0d lane errors all_done=%0d, required 0/1 (dest %b)", bad, done_cyc.size(), d);
        end
        $display("[TB] orphan: dest=%b pops=%0d drop_err=%0d", d, pop_cyc.size(), derr_cyc.size());
    endtask

    task automatic test_empty_stall();
        bit ok;
        int s1, n, bad;
        clear_logs();
        bus.calls = '1; bus.ready_vec = '1;
        add_packet(6'b000001, 1);
        n = 0;
        while (rx[0].size() < 2 && n < 20) begin step(); n++; end
        tests++;
        if (rx[0].size() < 2) begin
            fails++; $display("FAIL empty_start: %0d phits after %0d cycles, required 2", rx[0].size(), n);
        end
        force_empty = 1'b1;
        step();
        s1 = rx[0].size();
        step(); step();
        tests++;
        if (rx[0].size() != s1 || pop_cyc.size() != 0) begin
            fails++; $display("FAIL empty_freeze: phits %0d->%0d pops=%0d, required unchanged/0", s1, rx[0].size(), pop_cyc.size());
        end
        tests++;
        if (bus.sent_req_vec !== 6'b000001) begin
            fails++; $display("FAIL empty_req_held: sent_req=%b, required 000001", bus.sent_req_vec);
        end
        force_empty = 1'b0;
        drain(0, 100, ok);
        bad = 0;
        for (int j = 0; j < rx[0].size() && j < exp_q[0].size(); j++) if (rx[0][j] !== exp_q[0][j]) bad++;
        tests++;
        if (!ok || bad != 0 || rx[0].size() != FS || done_cyc.size() != 1) begin
            fails++; $display("FAIL empty_resume: phits=%0d wrong=%0d done=%0d, required %0d/0/1", rx[0].size(), bad, done_cyc.size(), FS);
        end
        $display("[TB] empty_stall: %0d phits delivered", rx[0].size());
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n, bad;
        clear_logs();
        bus.calls = '1; bus.ready_vec = '1;
        add_packet(6'b001000, 3);
        n = 0;
        while (rx[3].size() < 2 && n < 20) begin step(); n++; end
        reset = 1'b1;
        #1;
        tests++;
        if (bus.new_vec !== '0 || bus.outdata !== '0 || bus.all_done !== 1'b0 || bus.drop_err !== 1'b0) begin
            fails++; $display("FAIL midreset_regs: new_vec=%b outdata=%h done=%b derr=%b, required 0",
                              bus.new_vec, bus.outdata, bus.all_done, bus.drop_err);
        end
        tests++;
        if (bus.want !== 1'b0 || bus.sent_req_vec !== '0 || done_cyc.size() != 0) begin
            fails++; $display("FAIL midreset_comb: want=%b req=%b done=%0d, required 0", bus.want, bus.sent_req_vec, done_cyc.size());
        end
        // The upstream buffer abandons the partly sent head flit; its body and tail arrive orphaned.
        void'(q.pop_front());
        force_empty = 1'b1;
        drive_inputs();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        force_empty = 1'b0;
        clear_logs();
        exp_pops = 2; exp_derr = 2;
        add_packet(6'b001000, 1);
        drain(0, 100, ok);
        tests++;
        if (!ok || pop_cyc.size() != exp_pops || derr_cyc.size() != exp_derr || done_cyc.size() != exp_done) begin
            fails++; $display("FAIL midreset_recover: pops=%0d derr=%0d done=%0d, required %0d/%0d/%0d",
                              pop_cyc.size(), derr_cyc.size(), done_cyc.size(), exp_pops, exp_derr, exp_done);
        end
        bad = 0;
        for (int j = 0; j < rx[3].size() && j < exp_q[3].size(); j++) if (rx[3][j] !== exp_q[3][j]) bad++;
        tests++;
        if (bad != 0 || rx[3].size() != exp_q[3].size()) begin
            fails++; $display("FAIL midreset_data: got %0d phits (%0d wrong), required %0d", rx[3].size(), bad, exp_q[3].size());
        end
        $display("[TB] reset_mid: %0d drops, %0d phits after recovery", derr_cyc.size(), rx[3].size());
    endtask

    task automatic test_random();
        bit ok;
        int bad;
        logic [NO-1:0] d;
        clear_logs();
        for (int p = 0; p < 14; p++) begin
            if ($urandom_range(0, 5) == 0) push_orphan();
            d = ($urandom_range(0, 6) == 0) ? '0 : NO'($urandom_range(1, 63));
            add_packet(d, $urandom_range(1, 3));
        end
        drain(2, 4000, ok);
        tests++;
        if (!ok || pop_cyc.size() != exp_pops) begin
            fails++; $display("FAIL random_pops: drained=%0d pops=%0d, required 1/%0d", ok, pop_cyc.size(), exp_pops);
        end
        for (int i = 0; i < NO; i++) begin
            bad = 0;
            for (int j = 0; j < rx[i].size() && j < exp_q[i].size(); j++) if (rx[i][j] !== exp_q[i][j]) bad++;
            tests++;
            if (bad != 0 || rx[i].size() != exp_q[i].size()) begin
                fails++; $display("FAIL random_data lane%0d: got %0d phits (%0d wrong), required %0d", i, rx[i].size(), bad, exp_q[i].size());
            end
        end
        tests++;
        if (done_cyc.size() != exp_done || derr_cyc.size() != exp_derr) begin
            fails++; $display("FAIL random_pulses: all_done=%0d drop_err=%0d, required %0d/%0d",
                              done_cyc.size(), derr_cyc.size(), exp_done, exp_derr);
        end
        tests++;
        if (proto_viol != 0) begin
            fails++; $display("FAIL random_protocol: %0d phits without grant+ready or nonzero idle data, required 0", proto_viol);
        end
        bus.calls = '1; bus.ready_vec = '1;
        $display("[TB] random: %0d pops, %0d all_done, %0d drop_err", pop_cyc.size(), done_cyc.size(), derr_cyc.size());
    endtask

    initial begin
        reset = 1'b1;
        force_empty = 1'b0;
        cyc = 0;
        bus.calls = '0; bus.ready_vec = '0;
        clear_logs();
        drive_inputs();
        test_reset();
        test_unicast();
        test_multicast();
        test_zero_dest();
        test_orphan();
        test_empty_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/inport_multicast_distributor.md
# inport_multicast_distributor

Input-port right-side distributor for the multi-phit router. Pops flits from the input buffer and serialises each flit phit-by-phit onto every output lane named in the packet's destination vector. Each lane advances independently under its own grant and ready, and flits stay in lockstep across lanes. An internal packet state machine replaces the external `state` input used by the previous generation, and the block adds zero-destination and orphan-flit handling.

## Interface
Parameters:
- `no_outport`, 6, number of output lanes
- `flit_size`, 4, phits per flit (≥1)
- `floorplusone_log2_flit_size`, 3, phit-counter width, floor(log2(flit_size))+1
- `phit_size`, 16, bits per phit

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `indata`  in  flit_size*phit_size  flit at input-buffer head; phit k at bits [(k+1)*phit_size-1 : k*phit_size]
- `head`, `tail`, `empty`  in  1  input-buffer flags for the flit at `indata`
- `outport_vec`  in  no_outport  destination set; sampled only with a head flit
- `calls`  in  no_outport  per-lane grant from output arbiters
- `ready_vec`  in  no_outport  per-lane downstream can accept a phit this cycle
- `outdata`  out  no_outport*phit_size  registered per-lane phit
- `new_vec`  out  no_outport  registered per-lane phit-valid
- `sent_req_vec`  out  no_outport  per-lane arbitration request
- `want`  out  1  combinational pop strobe to the input buffer
- `all_done`  out  1  registered one-cycle pulse: packet fully delivered
- `drop_err`  out  1  registered one-cycle pulse: flit or packet discarded

## Operation
States: IDLE, ACTIVE, DROP.
- IDLE, `!empty & head & |outport_vec`:
  - latch `dest_reg <= outport_vec`, clear all counters and `flit_done`.
  - go to ACTIVE.
- IDLE, `!empty & head & ~|outport_vec`: go to DROP.
- IDLE, `!empty & !head` (orphan flit):
  - `want=1`, pop and discard, `drop_err` pulse.
  - stay in IDLE.
- ACTIVE, lane i fires when `dest_reg[i] & calls[i] & ready_vec[i] & ~flit_done[i] & ~empty`.
- On fire:
  - next-cycle `outdata` lane i = phit `cnt[i]`, `new_vec[i]=1`.
  - `cnt[i]++`.
  - if `cnt[i]==flit_size-1`, set `flit_done[i]`.
- Non-firing lanes:
  - `new_vec[i]=0`, `outdata` lane i = 0.
- `lane_ok[i] = ~dest_reg[i] | flit_done[i] | (fire[i] & cnt[i]==flit_size-1)`.
- `want = ACTIVE & ~empty & (&lane_ok)`. On pop:
  - clear all `cnt` and `flit_done` next cycle.
  - if `tail`: clear `dest_reg`, pulse `all_done`, go to IDLE.
- A lane that finishes a flit early idles until the whole flit is popped; there is no skew across flits.
- `sent_req_vec = dest_reg & ~pkt_done`. `pkt_done[i]` is set when lane i completes the tail flit, dropping that lane's request as soon as it is served. `pkt_done` clears on the return to IDLE.
- DROP:
  - `want = ~empty`, each flit discarded.
  - on the tail pop: `drop_err` pulse, go to IDLE.
- `empty` mid-packet:
  - no fires, counters hold, requests stay asserted.

## Timing
- Phit latency: fire in cycle T gives `new_vec`/`outdata` valid in T+1.
- Pop: `want` is combinational in the same cycle as the final fire, and the buffer advances at the clock edge.
- Back-to-back packets:
  - tail pop at T; IDLE and `all_done` at T+1.
  - next head latched at T+1; requests from T+2.
- Single-phit flits (`flit_size==1`): every fire completes the lane; a head+tail flit is a one-flit packet.
- Fire and pop in the same cycle are legal; cleared counters take priority over the increment.
- Reset (asynchronous):
  - state IDLE; `dest_reg`, counters, `flit_done`, `pkt_done` zero.
  - `outdata`, `new_vec`, `all_done`, `drop_err` = 0.
  - `want` and `sent_req_vec` forced 0 while `reset` is high.
- Reset mid-packet abandons the packet with no `all_done`. The remaining flits arrive orphaned and are dropped with `drop_err`.

## Structure
- Shared package `noc_pkg`:
  - state encodings `ST_IDLE`/`ST_ACTIVE`/`ST_DROP`
  - `clog2`-style width function
- One sub-module, `inport_lane_counter`, instantiated per lane: phit counter plus `flit_done`/`pkt_done` flags. Inputs: fire, pop, tail, clear. Outputs: `cnt`, `flit_done`, `pkt_done`.
- Top level holds the FSM, `dest_reg`, the `want`/`sent_req_vec` logic and the output registers.

## Test plan
- Unicast, `flit_size=4`, dest `6'b000100`, lane 2 granted and always ready, 2-flit packet: 8 phits on lane 2 in order.
  - `want` high on phits 4 and 8.
  - `all_done` one cycle after the second pop; `sent_req_vec[2]` falls after phit 8.
- Multicast dest `6'b100011`, lane 5 ready only on alternate cycles:
  - lanes 0/1 finish each flit and wait.
  - `want` is asserted only when lane 5 emits phit 3.
  - all lanes receive identical phit sequences.
- Zero destination, 3-flit packet: three pops; no `new_vec`; one `drop_err` on the tail pop; no `all_done`.
- Orphan body flit in IDLE: popped, `drop_err` pulse, following head packet delivered normally.
- `empty` asserted mid-flit for 3 cycles: no fires, counters frozen, requests held, delivery resumes at the correct phit.
- Async reset mid-packet after 2 of 4 phits: all outputs 0 immediately. The post-reset body flits are dropped, then a new head packet is delivered correctly.
